lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the word-wide, single-port, 1-cycle-read-latency data RAM bus. It accepts one load or store request at a time from the core, issues RAM transactions, and returns one response per request. Byte and halfword stores use read-modify-write, because the RAM writes whole words only. Byte and halfword loads are lane-extracted and sign- or zero-extended. The block sits between the execute stage and the data RAM.

## Interface
- `SIZE`, 1024: RAM depth in 32-bit words; word index ≥ SIZE is out of range.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, illegal funct3 or out-of-range; valid with `resp_valid`.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: RAM byte address, bits [1:0] always 0.
- `mem_wd` out 32: RAM write data.
- `mem_rd` in 32: RAM read data; reflects the address sampled at the previous edge.

## Operation
- States: IDLE, REQ, CAPT, MERGE, RESP.
- All `mem_*` and `resp_*` outputs are registered. `req_ready = (state == IDLE)`.
- IDLE, accept (`req_valid && req_ready`):
  - Latch `we`, `funct3`, `addr[1:0]` and `wdata`.
  - If error: go to RESP with `resp_err` set; no RAM access; `mem_we` stays 0.
  - Otherwise: `mem_addr <= {addr[31:2],2'b00}`; `mem_we <=` (SW); `mem_wd <= wdata`; go to REQ.
- REQ: `mem_we <= 0`. SW goes to RESP; all other accesses go to CAPT.
- CAPT: `mem_rd` is valid.
  - Load: `resp_rdata <=` extracted lane, then go to RESP.
    - Byte lane = `mem_rd[8*a+7 -: 8]` with `a = addr[1:0]`.
    - Half lane = `mem_rd[16*addr[1]+15 -: 16]`.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - SB/SH: `mem_wd <= mem_rd` with the addressed lane replaced by `wdata[7:0]` / `wdata[15:0]`; `mem_we <= 1`; go to MERGE.
- MERGE: `mem_we <= 0`; go to RESP.
- RESP: `resp_valid = 1` for exactly one cycle; go to IDLE. `resp_rdata` and `resp_err` are cleared on the next accept.
- Error conditions:
  - Misaligned: H with `addr[0]`; W with `addr[1:0] != 0`.
  - Illegal funct3: loads 011/110/111; stores > 010.
  - Out of range: `addr[31:2] >= SIZE`.
- Little-endian lane numbering throughout.

## Timing
- Accept in cycle 0. `resp_valid` asserts in:
  - Error: cycle 1.
  - SW: cycle 2.
  - Loads: cycle 3.
  - SB/SH: cycle 4.
- Write pulses:
  - SW: `mem_we` high in cycle 1 only.
  - SB/SH: `mem_we` high in cycle 3 only; the read uses cycle 1 address and cycle 2 data.
- Throughput: next accept no earlier than the cycle after RESP. `req_valid` while not ready is ignored, and the requester holds it.
- Reset values: state IDLE; `mem_we`, `mem_addr`, `mem_wd`, `resp_valid`, `resp_rdata`, `resp_err` all 0; `req_ready` is 1 in the first cycle after reset.
- Reset mid-operation: abort with no response. `mem_we` is 0 from the cycle after reset. A word is written either entirely or not at all: RMW aborted before MERGE leaves the RAM unchanged.
- The RAM reads every cycle; reads issued during REQ/MERGE have no side effects.

## Structure
- Shared header `include/lsu_defs.vh`: funct3 width codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and state encodings. The decoder uses the same width codes.
- Sub-module `lsu_align` (combinational), with two functions:
  - load extract/extend from (`mem_rd`, `addr[1:0]`, `funct3`);
  - store merge from (`mem_rd`, `wdata`, `addr[1:0]`, `funct3`).
  - Reused by any future cache.
- `lsu` holds the FSM and registers.

## Test plan
- SW at 0x10 with data 0xDEADBEEF:
  - `mem_we` high in cycle 1 at `mem_addr` 0x10.
  - `resp_valid` in cycle 2 with `err=0`.
  - Subsequent LW 0x10 returns 0xDEADBEEF in cycle 3.
- RAM word 0x10 = 0x8040FF7F:
  - LB 0x10 → 0x0000007F.
  - LB 0x11 → 0xFFFFFFFF.
  - LBU 0x11 → 0x000000FF.
  - LH 0x12 → 0xFFFF8040.
  - LHU 0x12 → 0x00008040.
- RAM word 0x20 = 0x11223344:
  - SB 0x22 with data 0xAB writes 0x11AB3344 in cycle 3; response in cycle 4.
  - SH 0x20 with data 0xBEEF then yields 0x11ABBEEF.
- Errors: LW 0x13, SH 0x21, funct3 011 load, and addr 4*SIZE:
  - `resp_err=1` in cycle 1 with `rdata=0`.
  - `mem_we` never asserted.
- Reset asserted in cycle 2 of an SB (CAPT):
  - No write and no `resp_valid`.
  - RAM word unchanged.
  - `req_ready=1` in the cycle after reset deasserts.
- Back-to-back requests with `req_valid` held high:
  - Each request is accepted only in IDLE.
  - Exactly one `resp_valid` per accept, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states and RV32I width codes.
package lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCapt,
        StMerge,
        StResp
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width code legality: stores only have B/H/W, loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            return a[0];
        end
        if (f3 == F3_W) begin
            return a != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merging for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] a,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {a, 3'b000});
        h = 16'(rd >> {a[1], 4'b0000});
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            F3_W:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    // Replace only the addressed lane; words pass the store data straight through.
    function automatic logic [31:0] store_merge(input logic [31:0] rd, input logic [31:0] wd,
                                                input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            F3_B: begin
                mask = 32'h0000_00ff << {a, 3'b000};
                data = {4{wd[7:0]}};
            end
            F3_H: begin
                mask = 32'h0000_ffff << {a[1], 4'b0000};
                data = {2{wd[15:0]}};
            end
            default: begin
                mask = 32'hffff_ffff;
                data = wd;
            end
        endcase
        return (rd & ~mask) | (data & mask);
    endfunction

    // Pure combinational lane logic.
    always_comb begin
        load_data  = load_extract(mem_rd, addr_lo, funct3);
        store_data = store_merge(mem_rd, wdata, addr_lo, funct3);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: FSM driving a 1-cycle-latency word RAM, RMW for sub-word stores.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_err;
    logic        req_oor;
    logic        is_sw_q;
    logic [31:0] load_data;
    logic [31:0] store_data;

    lsu_align u_align (
        .mem_rd     (mem_rd),
        .wdata      (wdata_q),
        .addr_lo    (alo_q),
        .funct3     (f3_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Request decode and output wiring.
    always_comb begin
        req_oor    = 32'(req_addr[31:2]) >= SIZE;
        req_err    = !f3_legal(req_we, req_funct3) ||
                     f3_misaligned(req_funct3, req_addr[1:0]) || req_oor;
        is_sw_q    = we_q && (f3_q == F3_W);
        req_ready  = (state_q == StIdle);
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wd     = mem_wd_q;
    end

    // Next-state logic; resp_valid_d is raised on every transition into StResp.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        alo_d        = alo_q;
        wdata_d      = wdata_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d         = req_we;
                    f3_d         = req_funct3;
                    alo_d        = req_addr[1:0];
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (req_err) begin
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        mem_we_d   = req_we && (req_funct3 == F3_W);
                        mem_wd_d   = req_wdata;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                mem_we_d = 1'b0;
                if (is_sw_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (!we_q) begin
                    resp_rdata_d = load_data;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    mem_wd_d = store_data;
                    mem_we_d = 1'b1;
                    state_d  = StMerge;
                end
            end
            StMerge: begin
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            alo_q        <= 2'b00;
            wdata_q      <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wd_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            alo_q        <= alo_d;
            wdata_q      <= wdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: behavioural RAM, byte-level reference model.
module tb_lsu;

    localparam int unsigned SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:SIZE-1];
    logic [31:0] ref_mem [0:SIZE-1];

    int          obs_lat;
    int          obs_wcnt;
    int          obs_wcyc;
    logic [31:0] obs_waddr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;
    logic        obs_err;

    lsu #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[11:2]] <= mem_wd;
        mem_rd <= ram[mem_addr[11:2]];
    end

    // ---- reference model ----
    function automatic int m_bytes(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic illegal;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        return illegal || ((addr % m_bytes(f3)) != 0) || ((addr / 4) >= SIZE);
    endfunction

    function automatic int m_lat(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (m_err(we, f3, addr)) return 1;
        if (we && f3 == 3'b010) return 2;
        if (we) return 4;
        return 3;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [2:0] f3);
        logic [31:0] v;
        int          off;
        off = addr % 4;
        if (m_bytes(f3) == 1) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (m_bytes(f3) == 2) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] addr,
                                            input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] mask;
        int          off;
        off = addr % 4;
        if (m_bytes(f3) == 4) return wd;
        mask = ((32'h1 << (8 * m_bytes(f3))) - 1) << (8 * off);
        return (w & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    // Issue one request and record what the DUT does until its response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 0; obs_wcnt = 0; obs_wcyc = 0; obs_waddr = 0; obs_wdata = 0;
        obs_rdata = 0; obs_err = 0;
        for (int c = 1; c <= 8 && obs_lat == 0; c++) begin
            if (mem_we) begin
                obs_wcnt++; obs_wcyc = c; obs_waddr = mem_addr; obs_wdata = mem_wd;
            end
            if (resp_valid) begin
                obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Model-side store bookkeeping.
    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        ref_mem[addr[11:2]] = m_store(ref_mem[addr[11:2]], addr, f3, wd);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b we=%b rv=%b required 1 0 0",
                     req_ready, mem_we, resp_valid);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wd !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
        begin
            failures++;
            $display("FAIL reset_data: addr=%h wd=%h rd=%h err=%b required zeros",
                     mem_addr, mem_wd, resp_rdata, resp_err);
        end
    endtask

    task automatic test_sw_lw;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        ref_store(3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if (obs_wcnt !== 1 || obs_wcyc !== 1 || obs_waddr !== 32'h10 || obs_wdata !== 32'hDEADBEEF)
        begin
            failures++;
            $display("FAIL sw_write: cnt=%0d cyc=%0d addr=%h data=%h required 1 1 10 deadbeef",
                     obs_wcnt, obs_wcyc, obs_waddr, obs_wdata);
        end
        checks++;
        if (obs_lat !== 2 || obs_err !== 1'b0) begin
            failures++;
            $display("FAIL sw_resp: lat=%0d err=%b required 2 0", obs_lat, obs_err);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if (obs_lat !== 3 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0 || obs_wcnt !== 0)
        begin
            failures++;
            $display("FAIL lw_resp: lat=%0d rd=%h err=%b wcnt=%0d required 3 deadbeef 0 0",
                     obs_lat, obs_rdata, obs_err, obs_wcnt);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5];
        logic [31:0] ads [5];
        logic [31:0] exp [5];
        f3s = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        ads = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h12};
        exp = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8040, 32'h00008040};
        do_req(1'b1, 3'b010, 32'h10, 32'h8040FF7F);
        ref_store(3'b010, 32'h10, 32'h8040FF7F);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0);
            checks++;
            if (obs_rdata !== exp[i] || obs_lat !== 3 || obs_err !== 1'b0) begin
                failures++;
                $display("FAIL load_lane%0d: rd=%h lat=%0d err=%b required %h 3 0",
                         i, obs_rdata, obs_lat, obs_err, exp[i]);
            end
        end
    endtask

    task automatic test_rmw;
        do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
        ref_store(3'b010, 32'h20, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h22, 32'h000000AB);
        ref_store(3'b000, 32'h22, 32'h000000AB);
        checks++;
        if (obs_wcnt !== 1 || obs_wcyc !== 3 || obs_waddr !== 32'h20 || obs_wdata !== 32'h11AB3344)
        begin
            failures++;
            $display("FAIL sb_write: cnt=%0d cyc=%0d addr=%h data=%h required 1 3 20 11ab3344",
                     obs_wcnt, obs_wcyc, obs_waddr, obs_wdata);
        end
        checks++;
        if (obs_lat !== 4 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            failures++;
            $display("FAIL sb_resp: lat=%0d err=%b rd=%h required 4 0 0",
                     obs_lat, obs_err, obs_rdata);
        end
        do_req(1'b1, 3'b001, 32'h20, 32'h0000BEEF);
        ref_store(3'b001, 32'h20, 32'h0000BEEF);
        checks++;
        if (obs_wdata !== 32'h11ABBEEF || ram[8] !== 32'h11ABBEEF || obs_lat !== 4) begin
            failures++;
            $display("FAIL sh_merge: wd=%h ram=%h lat=%0d required 11abbeef 11abbeef 4",
                     obs_wdata, ram[8], obs_lat);
        end
    endtask

    task automatic test_errors;
        logic        wes [4];
        logic [2:0]  f3s [4];
        logic [31:0] ads [4];
        wes = '{1'b0, 1'b1, 1'b0, 1'b0};
        f3s = '{3'b010, 3'b001, 3'b011, 3'b010};
        ads = '{32'h13, 32'h21, 32'h10, 32'(4 * SIZE)};
        for (int i = 0; i < 4; i++) begin
            // Leave a nonzero rdata behind so the clear on accept is visible.
            do_req(1'b0, 3'b010, 32'h20, 32'h0);
            do_req(wes[i], f3s[i], ads[i], 32'hFFFFFFFF);
            checks++;
            if (obs_err !== 1'b1 || obs_lat !== 1 || obs_rdata !== 32'h0 || obs_wcnt !== 0) begin
                failures++;
                $display("FAIL err_case%0d: err=%b lat=%0d rd=%h wcnt=%0d required 1 1 0 0",
                         i, obs_err, obs_lat, obs_rdata, obs_wcnt);
            end
        end
    endtask

    task automatic test_reset_abort;
        int bad;
        do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
        ref_store(3'b010, 32'h30, 32'hCAFEF00D);
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h31; req_wdata = 32'h55;
        @(posedge clk); #1;                 // cycle 1
        req_valid = 1'b0;
        bad = 0;
        if (mem_we || resp_valid) bad++;
        @(posedge clk); #1;                 // cycle 2 (CAPT)
        if (mem_we || resp_valid) bad++;
        rst = 1'b1;
        @(posedge clk); #1;
        if (mem_we || resp_valid) bad++;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: req_ready=%b required 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_we || resp_valid) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet: we/resp cycles=%0d required 0", bad);
        end
        checks++;
        if (ram[12] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL abort_ram: word=%h required cafef00d", ram[12]);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] e_rd;
        logic        e_err;
        for (int w = 64; w < 80; w++) begin
            wd = $urandom;
            do_req(1'b1, 3'b010, 32'(w * 4), wd);
            ref_store(3'b010, 32'(w * 4), wd);
        end
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) addr = 32'(4 * SIZE) + $urandom;
            wd   = $urandom;
            e_err = m_err(we, f3, addr);
            e_rd  = (e_err || we) ? 32'h0 : m_load(ref_mem[addr[11:2]], addr, f3);
            do_req(we, f3, addr, wd);
            checks++;
            if (obs_err !== e_err || obs_rdata !== e_rd || obs_lat !== m_lat(we, f3, addr)) begin
                failures++;
                $display("FAIL rand%0d we=%b f3=%0d a=%h: err=%b rd=%h lat=%0d required %b %h %0d",
                         i, we, f3, addr, obs_err, obs_rdata, obs_lat, e_err, e_rd,
                         m_lat(we, f3, addr));
            end
            if (we && !e_err) ref_store(f3, addr, wd);
            checks++;
            if (obs_wcnt !== ((we && !e_err) ? 1 : 0) ||
                (!e_err && ram[addr[11:2]] !== ref_mem[addr[11:2]])) begin
                failures++;
                $display("FAIL rand%0d_mem: wcnt=%0d word=%h required %0d %h", i, obs_wcnt,
                         ram[addr[11:2]], (we && !e_err) ? 1 : 0, ref_mem[addr[11:2]]);
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        logic        wes [N];
        logic [2:0]  f3s [N];
        logic [31:0] ads [N];
        logic [31:0] wds [N];
        logic [31:0] q_rd [$];
        logic        q_er [$];
        logic [31:0] exp_rd;
        logic        exp_er;
        int          idx;
        int          done;
        int          outstanding;
        int          cyc;
        logic        acc;
        for (int i = 0; i < N; i++) begin
            wes[i] = 1'($urandom_range(0, 1));
            f3s[i] = 3'($urandom_range(0, 5));
            ads[i] = 32'h100 + 32'($urandom_range(0, 15));
            wds[i] = $urandom;
        end
        while (!req_ready) begin @(posedge clk); #1; end
        idx = 0; done = 0; outstanding = 0; cyc = 0;
        req_valid = 1'b1; req_we = wes[0]; req_funct3 = f3s[0];
        req_addr = ads[0]; req_wdata = wds[0];
        while (done < N && cyc < 400) begin
            checks++;
            if (req_ready !== (outstanding == 0)) begin
                failures++;
                $display("FAIL b2b_ready cyc%0d: ready=%b required %b", cyc, req_ready,
                         outstanding == 0);
            end
            if (resp_valid) begin
                checks++;
                if (q_rd.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_resp: resp_valid with none outstanding");
                end else begin
                    exp_rd = q_rd.pop_front();
                    exp_er = q_er.pop_front();
                    if (resp_rdata !== exp_rd || resp_err !== exp_er) begin
                        failures++;
                        $display("FAIL b2b_resp%0d: rd=%h err=%b required %h %b",
                                 done, resp_rdata, resp_err, exp_rd, exp_er);
                    end
                end
                done++;
                outstanding = 0;
            end
            acc = req_ready && (idx < N);
            if (acc) begin
                exp_er = m_err(wes[idx], f3s[idx], ads[idx]);
                exp_rd = (exp_er || wes[idx]) ? 32'h0
                                              : m_load(ref_mem[ads[idx][11:2]], ads[idx], f3s[idx]);
                q_rd.push_back(exp_rd);
                q_er.push_back(exp_er);
                if (wes[idx] && !exp_er) ref_store(f3s[idx], ads[idx], wds[idx]);
                outstanding = 1;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx < N) begin
                    req_we = wes[idx]; req_funct3 = f3s[idx];
                    req_addr = ads[idx]; req_wdata = wds[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (done != N || idx != N) begin
            failures++;
            $display("FAIL b2b_count: responses=%0d accepts=%0d required %0d", done, idx, N);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = 32'h0;
        test_reset();
        test_sw_lw();
        test_loads();
        test_rmw();
        test_errors();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
